pipeline_sram_arbiter: RTL and testbench
========================================

# pipeline_sram_arbiter

Single-port SRAM scheduler for the foreground frame store. It shares one synchronous SRAM port among three requesters: display reads from the video pipeline, still-image pixel writes delivered by the SPI control block, and live foreground capture writes. Display reads always have priority. SPI pixels are converted from (x, y) to a linear address and buffered in a small FIFO. Capture writes are suppressed while the foreground is frozen.

## Interface
- PIXEL_SIZE, 16, pixel/data width
- PRECISION, 15, width of SPI pixel x/y coordinates
- RESOLUTION_X, 480, frame-store width in pixels
- RESOLUTION_Y, 270, frame-store height in pixels
- ADDR_WIDTH, 17, SRAM word address width; must satisfy RESOLUTION_X*RESOLUTION_Y <= 2^ADDR_WIDTH
- FIFO_DEPTH, 4, SPI pixel FIFO entries (power of two)

- clk  in  1  sole clock
- rst_n  in  1  asynchronous active-low reset
- rd_req  in  1  display read request, one per cycle, no backpressure
- rd_addr  in  ADDR_WIDTH  display read address
- rd_data  out  PIXEL_SIZE  read data
- rd_valid  out  1  rd_data valid, one-cycle pulse per rd_req
- img_pixel_x  in  PRECISION  SPI pixel column
- img_pixel_y  in  PRECISION  SPI pixel row
- img_pixel  in  PIXEL_SIZE  SPI pixel data
- img_pixel_ready  in  1  one-cycle strobe; the other img_* inputs are valid in this cycle
- cap_req  in  1  capture write request; held until cap_ack
- cap_addr  in  ADDR_WIDTH  capture address
- cap_data  in  PIXEL_SIZE  capture data
- cap_ack  out  1  one-cycle acknowledge; cap_req may drop or change in the next cycle
- ctrl_fg_freeze  in  1  when high, capture writes are acknowledged and discarded
- clr_err  in  1  clears the sticky error flags
- img_overflow  out  1  sticky: an SPI pixel was dropped because the FIFO was full
- img_oob  out  1  sticky: an SPI pixel was dropped because its coordinates were out of range
- sram_en  out  1  SRAM access enable
- sram_we  out  1  SRAM write enable
- sram_addr  out  ADDR_WIDTH  SRAM address
- sram_wdata  out  PIXEL_SIZE  SRAM write data
- sram_rdata  in  PIXEL_SIZE  SRAM read data; valid one cycle after a read access (sram_en=1, sram_we=0)

## Operation
- **Address stage (registered).** On img_pixel_ready, compute addr = y*RESOLUTION_X + x at full width and truncate to ADDR_WIDTH.
  - If x >= RESOLUTION_X or y >= RESOLUTION_Y: drop the pixel and set img_oob.
  - Otherwise latch {addr, pixel} and push it into the FIFO on the next edge.
- **FIFO push rules.**
  - Push while full with no pop in the same cycle: drop the pixel and set img_overflow.
  - Push and pop in the same cycle while full: the push is accepted.
- **Arbiter.** Decides each cycle; the grant is encoded as state GNT_NONE / GNT_RD / GNT_IMG / GNT_CAP.
  - Candidates: rd_req; FIFO non-empty; cap_req with ctrl_fg_freeze=0.
  - rd_req always wins.
  - Between the two write requesters, use round-robin with a last_wr bit. On a tie, grant the requester not granted last. A lone requester is always granted.
- **Grant effects.**
  - GNT_IMG pops the FIFO.
  - GNT_CAP pulses cap_ack in the decision cycle.
- **Freeze.** cap_req with ctrl_fg_freeze=1 pulses cap_ack in the same cycle and generates no SRAM access. It does not change last_wr.
- **Registered SRAM outputs.** sram_en/sram_we/sram_addr/sram_wdata register the winning request. Under GNT_NONE, sram_en=0 and sram_we=0.
- **Read return.** rd_data is registered from sram_rdata. rd_valid follows a 2-deep pipeline of the read grant.
- **Error flags.** clr_err clears both flags. If a new error and clr_err occur in the same cycle, the flag is set.
- **Reset.** All outputs are 0, the FIFO is empty, and last_wr = CAP, so the image FIFO wins the first tie.
  - Asserting reset mid-operation discards FIFO contents and the address stage.
  - Reads in flight produce no rd_valid.

## Timing
- **Read.** rd_req sampled in cycle T → sram_en=1, sram_we=0 in T+1 → rd_valid=1 with data in T+3. Latency is fixed at 3, with full throughput of one read per cycle.
- **SPI write.** img_pixel_ready in T → address stage T+1 → FIFO entry visible T+2. With no contention, sram_we=1 in T+3.
- **Capture write.** cap_req granted in cycle T → cap_ack=1 in T → sram_we=1 in T+1.
- **Starvation.** Continuous rd_req starves both write requesters indefinitely. The FIFO then fills and overflows; this is intended, because the display is real-time.
- **Relative order.** Writes to the same address from different requesters take effect in grant order.

## Test plan
- SPI write (x=10, y=2, pixel=16'hABCD) with the bus idle → sram_addr=970, sram_wdata=16'hABCD, sram_we=1 exactly 3 cycles after the strobe.
- Corner pixel (479, 269) → sram_addr=129599. Pixel (480, 0) → no SRAM write, img_oob=1. clr_err → img_oob=0.
- rd_req on 8 consecutive cycles with sram_rdata = address-derived pattern → 8 rd_valid pulses in order, each 3 cycles after its request. A concurrent 6-pixel SPI burst → 4 queued, 2 dropped, img_overflow=1. After the reads stop, the 4 queued pixels are written in order.
- cap_req held high with the FIFO kept non-empty → grants alternate IMG, CAP, IMG, CAP. cap_ack pulses once per CAP grant.
- ctrl_fg_freeze=1 with cap_req → cap_ack in the same cycle, sram_en stays 0.
- Assert rst_n=0 with 3 FIFO entries and 2 reads in flight → all outputs 0, no rd_valid, no writes after release.

Source files
------------

// File: rtl/pipeline_sram_arbiter_if.sv
// Signal bundle between the frame-store requesters (display read, SPI pixel
// writes, live capture writes) and the single-port SRAM scheduler, including
// the SRAM port itself. The arbiter uses the slave view.
interface pipeline_sram_arbiter_if #(
  parameter int PIXEL_SIZE = 16,
  parameter int PRECISION  = 15,
  parameter int ADDR_WIDTH = 17
);
  // Display read path
  logic                  rd_req;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [PIXEL_SIZE-1:0] rd_data;
  logic                  rd_valid;
  // SPI still-image pixel path
  logic [PRECISION-1:0]  img_pixel_x;
  logic [PRECISION-1:0]  img_pixel_y;
  logic [PIXEL_SIZE-1:0] img_pixel;
  logic                  img_pixel_ready;
  // Live capture path
  logic                  cap_req;
  logic [ADDR_WIDTH-1:0] cap_addr;
  logic [PIXEL_SIZE-1:0] cap_data;
  logic                  cap_ack;
  // Control and status
  logic                  ctrl_fg_freeze;
  logic                  clr_err;
  logic                  img_overflow;
  logic                  img_oob;
  // SRAM port
  logic                  sram_en;
  logic                  sram_we;
  logic [ADDR_WIDTH-1:0] sram_addr;
  logic [PIXEL_SIZE-1:0] sram_wdata;
  logic [PIXEL_SIZE-1:0] sram_rdata;

  modport slave (
    input  rd_req, rd_addr,
    output rd_data, rd_valid,
    input  img_pixel_x, img_pixel_y, img_pixel, img_pixel_ready,
    input  cap_req, cap_addr, cap_data,
    output cap_ack,
    input  ctrl_fg_freeze, clr_err,
    output img_overflow, img_oob,
    output sram_en, sram_we, sram_addr, sram_wdata,
    input  sram_rdata
  );

  modport master (
    output rd_req, rd_addr,
    input  rd_data, rd_valid,
    output img_pixel_x, img_pixel_y, img_pixel, img_pixel_ready,
    output cap_req, cap_addr, cap_data,
    input  cap_ack,
    output ctrl_fg_freeze, clr_err,
    input  img_overflow, img_oob,
    input  sram_en, sram_we, sram_addr, sram_wdata,
    output sram_rdata
  );
endinterface

// File: rtl/pipeline_sram_arbiter.sv
// Single-port SRAM scheduler for the foreground frame store. Display reads
// always win; SPI pixels (after x/y -> linear address conversion and a small
// FIFO) and capture writes share the remaining slots round-robin. Capture
// writes are acknowledged and discarded while the foreground is frozen.
// Interface widths must match the parameters given here.
module pipeline_sram_arbiter #(
  parameter int PIXEL_SIZE   = 16,
  parameter int PRECISION    = 15,
  parameter int RESOLUTION_X = 480,
  parameter int RESOLUTION_Y = 270,
  parameter int ADDR_WIDTH   = 17,
  parameter int FIFO_DEPTH   = 4
) (
  input logic clk,
  input logic rst_n,
  pipeline_sram_arbiter_if.slave bus
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int CMP_W = PRECISION + 32;

  typedef enum logic [1:0] {GNT_NONE, GNT_RD, GNT_IMG, GNT_CAP} gnt_e;
  typedef enum logic {LAST_IMG, LAST_CAP} last_wr_e;

  // Address stage
  logic [ADDR_WIDTH-1:0] lin_addr;
  logic                  pix_oob;
  logic                  stg_valid_reg;
  logic [ADDR_WIDTH-1:0] stg_addr_reg;
  logic [PIXEL_SIZE-1:0] stg_data_reg;

  // Pixel FIFO
  logic [ADDR_WIDTH-1:0] fifo_addr_mem [FIFO_DEPTH];
  logic [PIXEL_SIZE-1:0] fifo_data_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_reg, rd_ptr_reg;
  logic [CNT_W-1:0]      fifo_count_reg;
  logic                  fifo_full, fifo_empty;
  logic                  fifo_push, fifo_pop, overflow_set;
  logic [ADDR_WIDTH-1:0] head_addr;
  logic [PIXEL_SIZE-1:0] head_data;

  // Arbiter and SRAM port
  gnt_e                  gnt_next, state_reg;
  last_wr_e              last_wr_reg;
  logic                  cap_live;
  logic                  sram_en_reg, sram_we_reg;
  logic [ADDR_WIDTH-1:0] sram_addr_reg;
  logic [PIXEL_SIZE-1:0] sram_wdata_reg;

  // Read return and error flags
  logic                  rd_stage2_reg, rd_valid_reg;
  logic [PIXEL_SIZE-1:0] rd_data_reg;
  logic                  oob_reg, overflow_reg;

  // Linear address and range check for the incoming SPI pixel. Only the low
  // ADDR_WIDTH bits of y*RESOLUTION_X + x are kept, and modular arithmetic
  // gives the same low bits when the operands are reduced first.
  always_comb begin
    lin_addr = ADDR_WIDTH'(bus.img_pixel_y) * ADDR_WIDTH'(RESOLUTION_X)
             + ADDR_WIDTH'(bus.img_pixel_x);
    pix_oob  = (CMP_W'(bus.img_pixel_x) >= CMP_W'(RESOLUTION_X))
            || (CMP_W'(bus.img_pixel_y) >= CMP_W'(RESOLUTION_Y));
  end

  // Address stage: latch in-range pixels for one cycle before the FIFO push.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_valid_reg <= 1'b0;
      stg_addr_reg  <= '0;
      stg_data_reg  <= '0;
    end else begin
      stg_valid_reg <= bus.img_pixel_ready && !pix_oob;
      stg_addr_reg  <= lin_addr;
      stg_data_reg  <= bus.img_pixel;
    end
  end

  // FIFO status; a full FIFO still accepts a push when it is popped in the same cycle.
  always_comb begin
    fifo_full    = (fifo_count_reg == CNT_W'(FIFO_DEPTH));
    fifo_empty   = (fifo_count_reg == '0);
    fifo_pop     = (gnt_next == GNT_IMG);
    fifo_push    = stg_valid_reg && (!fifo_full || fifo_pop);
    overflow_set = stg_valid_reg && fifo_full && !fifo_pop;
    head_addr    = fifo_addr_mem[rd_ptr_reg];
    head_data    = fifo_data_mem[rd_ptr_reg];
  end

  // FIFO storage; contents need no reset because the pointers gate them.
  always_ff @(posedge clk) begin
    if (fifo_push) begin
      fifo_addr_mem[wr_ptr_reg] <= stg_addr_reg;
      fifo_data_mem[wr_ptr_reg] <= stg_data_reg;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      fifo_count_reg <= '0;
    end else begin
      if (fifo_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (fifo_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({fifo_push, fifo_pop})
        2'b10:   fifo_count_reg <= fifo_count_reg + 1'b1;
        2'b01:   fifo_count_reg <= fifo_count_reg - 1'b1;
        default: fifo_count_reg <= fifo_count_reg;
      endcase
    end
  end

  // Grant decision: reads first, then round-robin between the write sources.
  always_comb begin
    cap_live = bus.cap_req && !bus.ctrl_fg_freeze;
    gnt_next = GNT_NONE;
    if (bus.rd_req)
      gnt_next = GNT_RD;
    else if (!fifo_empty && cap_live)
      gnt_next = (last_wr_reg == LAST_CAP) ? GNT_IMG : GNT_CAP;
    else if (!fifo_empty)
      gnt_next = GNT_IMG;
    else if (cap_live)
      gnt_next = GNT_CAP;
  end

  // A frozen capture request is swallowed immediately, independent of the grant.
  assign bus.cap_ack = (gnt_next == GNT_CAP) || (bus.cap_req && bus.ctrl_fg_freeze);

  // Register the winning request onto the SRAM port and track write history.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= GNT_NONE;
      last_wr_reg    <= LAST_CAP;
      sram_en_reg    <= 1'b0;
      sram_we_reg    <= 1'b0;
      sram_addr_reg  <= '0;
      sram_wdata_reg <= '0;
    end else begin
      state_reg <= gnt_next;
      case (gnt_next)
        GNT_RD: begin
          sram_en_reg    <= 1'b1;
          sram_we_reg    <= 1'b0;
          sram_addr_reg  <= bus.rd_addr;
          sram_wdata_reg <= '0;
        end
        GNT_IMG: begin
          sram_en_reg    <= 1'b1;
          sram_we_reg    <= 1'b1;
          sram_addr_reg  <= head_addr;
          sram_wdata_reg <= head_data;
          last_wr_reg    <= LAST_IMG;
        end
        GNT_CAP: begin
          sram_en_reg    <= 1'b1;
          sram_we_reg    <= 1'b1;
          sram_addr_reg  <= bus.cap_addr;
          sram_wdata_reg <= bus.cap_data;
          last_wr_reg    <= LAST_CAP;
        end
        default: begin
          sram_en_reg    <= 1'b0;
          sram_we_reg    <= 1'b0;
          sram_addr_reg  <= '0;
          sram_wdata_reg <= '0;
        end
      endcase
    end
  end

  // Read return: the registered read grant is stage one, so rd_valid lands
  // together with the data captured from sram_rdata three cycles after rd_req.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_stage2_reg <= 1'b0;
      rd_valid_reg  <= 1'b0;
      rd_data_reg   <= '0;
    end else begin
      rd_stage2_reg <= (state_reg == GNT_RD);
      rd_valid_reg  <= rd_stage2_reg;
      if (rd_stage2_reg) rd_data_reg <= bus.sram_rdata;
    end
  end

  // Sticky error flags; a new error wins over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oob_reg      <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      oob_reg      <= (bus.img_pixel_ready && pix_oob) || (oob_reg && !bus.clr_err);
      overflow_reg <= overflow_set || (overflow_reg && !bus.clr_err);
    end
  end

  assign bus.sram_en      = sram_en_reg;
  assign bus.sram_we      = sram_we_reg;
  assign bus.sram_addr    = sram_addr_reg;
  assign bus.sram_wdata   = sram_wdata_reg;
  assign bus.rd_data      = rd_data_reg;
  assign bus.rd_valid     = rd_valid_reg;
  assign bus.img_oob      = oob_reg;
  assign bus.img_overflow = overflow_reg;

endmodule

// File: tb/tb_pipeline_sram_arbiter.sv
// Bench for pipeline_sram_arbiter: scenario tasks drive stimulus and push
// expected SRAM writes / read returns into queues; a scoreboard process pops
// and compares them as the DUT produces them, including the exact cycle.
module tb_pipeline_sram_arbiter;
  localparam int PIXEL_SIZE = 16;
  localparam int PRECISION  = 15;
  localparam int ADDR_WIDTH = 17;

  typedef struct {
    logic [ADDR_WIDTH-1:0] addr;
    logic [PIXEL_SIZE-1:0] data;
    int                    cyc;
  } wr_exp_t;

  typedef struct {
    logic [PIXEL_SIZE-1:0] data;
    int                    cyc;
  } rd_exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  wr_exp_t wr_q[$];
  rd_exp_t rd_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pipeline_sram_arbiter_if #(.PIXEL_SIZE(PIXEL_SIZE), .PRECISION(PRECISION),
                             .ADDR_WIDTH(ADDR_WIDTH)) bus ();

  pipeline_sram_arbiter #(
    .PIXEL_SIZE(PIXEL_SIZE), .PRECISION(PRECISION), .RESOLUTION_X(480),
    .RESOLUTION_Y(270), .ADDR_WIDTH(ADDR_WIDTH), .FIFO_DEPTH(4)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  function automatic logic [PIXEL_SIZE-1:0] pat(input logic [ADDR_WIDTH-1:0] a);
    return a[15:0] ^ 16'h5A5A;
  endfunction

  // SRAM model: read data appears one cycle after a read access.
  always @(posedge clk)
    if (bus.sram_en && !bus.sram_we) bus.sram_rdata <= pat(bus.sram_addr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.rd_req = 1'b0;          bus.rd_addr = '0;
    bus.img_pixel_x = '0;       bus.img_pixel_y = '0;
    bus.img_pixel = '0;         bus.img_pixel_ready = 1'b0;
    bus.cap_req = 1'b0;         bus.cap_addr = '0;
    bus.cap_data = '0;          bus.ctrl_fg_freeze = 1'b0;
    bus.clr_err = 1'b0;
  endtask

  task automatic drive_pixel(input int x, input int y, input int p);
    bus.img_pixel_x     = PRECISION'(x);
    bus.img_pixel_y     = PRECISION'(y);
    bus.img_pixel       = PIXEL_SIZE'(p);
    bus.img_pixel_ready = 1'b1;
  endtask

  task automatic push_wr(input int a, input int d, input int c);
    wr_q.push_back('{ADDR_WIDTH'(a), PIXEL_SIZE'(d), c});
  endtask

  // Pops expectations whenever the DUT writes the SRAM or returns read data.
  task automatic scoreboard_monitor();
    wr_exp_t w;
    rd_exp_t r;
    forever begin
      @(negedge clk);
      if (bus.sram_en === 1'b1 && bus.sram_we === 1'b1) begin
        checks++;
        if (wr_q.size() == 0) begin
          errors++;
          $display("FAIL sram_write: got addr=%0d data=%h cycle=%0d, required no write",
                   bus.sram_addr, bus.sram_wdata, cyc);
        end else begin
          w = wr_q.pop_front();
          if (bus.sram_addr !== w.addr || bus.sram_wdata !== w.data || cyc != w.cyc) begin
            errors++;
            $display("FAIL sram_write: got addr=%0d data=%h cycle=%0d, required addr=%0d data=%h cycle=%0d",
                     bus.sram_addr, bus.sram_wdata, cyc, w.addr, w.data, w.cyc);
          end else
            $display("write addr=%0d data=%h cycle=%0d", bus.sram_addr, bus.sram_wdata, cyc);
        end
      end
      if (bus.rd_valid === 1'b1) begin
        checks++;
        if (rd_q.size() == 0) begin
          errors++;
          $display("FAIL rd_valid: got data=%h cycle=%0d, required no read return", bus.rd_data, cyc);
        end else begin
          r = rd_q.pop_front();
          if (bus.rd_data !== r.data || cyc != r.cyc) begin
            errors++;
            $display("FAIL rd_return: got data=%h cycle=%0d, required data=%h cycle=%0d",
                     bus.rd_data, cyc, r.data, r.cyc);
          end else
            $display("read data=%h cycle=%0d", bus.rd_data, cyc);
        end
      end
    end
  endtask

  task automatic test_reset(input string tag);
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk);
    checks++; if (bus.sram_en !== 1'b0) begin errors++; $display("FAIL %s_sram_en: got %b, required 0", tag, bus.sram_en); end
    checks++; if (bus.sram_we !== 1'b0) begin errors++; $display("FAIL %s_sram_we: got %b, required 0", tag, bus.sram_we); end
    checks++; if (bus.sram_addr !== '0) begin errors++; $display("FAIL %s_sram_addr: got %0d, required 0", tag, bus.sram_addr); end
    checks++; if (bus.sram_wdata !== '0) begin errors++; $display("FAIL %s_sram_wdata: got %h, required 0", tag, bus.sram_wdata); end
    checks++; if (bus.rd_valid !== 1'b0) begin errors++; $display("FAIL %s_rd_valid: got %b, required 0", tag, bus.rd_valid); end
    checks++; if (bus.rd_data !== '0) begin errors++; $display("FAIL %s_rd_data: got %h, required 0", tag, bus.rd_data); end
    checks++; if (bus.cap_ack !== 1'b0) begin errors++; $display("FAIL %s_cap_ack: got %b, required 0", tag, bus.cap_ack); end
    checks++; if (bus.img_oob !== 1'b0) begin errors++; $display("FAIL %s_img_oob: got %b, required 0", tag, bus.img_oob); end
    checks++; if (bus.img_overflow !== 1'b0) begin errors++; $display("FAIL %s_img_overflow: got %b, required 0", tag, bus.img_overflow); end
    tick();
    tick();
    rst_n = 1'b1;
    repeat (8) tick();
    @(negedge clk);
    checks++; if (bus.sram_en !== 1'b0) begin errors++; $display("FAIL %s_after_release_sram_en: got %b, required 0", tag, bus.sram_en); end
    checks++;
    if (wr_q.size() != 0 || rd_q.size() != 0) begin
      errors++;
      $display("FAIL %s_pending: got %0d writes %0d reads outstanding, required 0", tag, wr_q.size(), rd_q.size());
    end
    tick();
  endtask

  task automatic test_spi_write();
    drive_pixel(10, 2, 16'hABCD);
    push_wr(970, 16'hABCD, cyc + 3);
    tick();
    idle_inputs();
    repeat (5) tick();
    checks++; if (wr_q.size() != 0) begin errors++; $display("FAIL spi_write_pending: got %0d outstanding, required 0", wr_q.size()); end
  endtask

  task automatic test_oob();
    drive_pixel(479, 269, 16'h1234);
    push_wr(129599, 16'h1234, cyc + 3);
    tick();
    drive_pixel(480, 0, 16'h5555);
    @(negedge clk);
    checks++; if (bus.img_oob !== 1'b0) begin errors++; $display("FAIL oob_corner_in_range: got %b, required 0", bus.img_oob); end
    tick();
    drive_pixel(0, 270, 16'h6666);
    tick();
    idle_inputs();
    @(negedge clk);
    checks++; if (bus.img_oob !== 1'b1) begin errors++; $display("FAIL oob_set: got %b, required 1", bus.img_oob); end
    repeat (4) tick();
    checks++; if (wr_q.size() != 0) begin errors++; $display("FAIL oob_pending: got %0d outstanding, required 0", wr_q.size()); end
    bus.clr_err = 1'b1;
    tick();
    bus.clr_err = 1'b0;
    @(negedge clk);
    checks++; if (bus.img_oob !== 1'b0) begin errors++; $display("FAIL oob_clear: got %b, required 0", bus.img_oob); end
    // New error together with a clear leaves the flag set.
    drive_pixel(600, 1, 16'h7777);
    bus.clr_err = 1'b1;
    tick();
    idle_inputs();
    @(negedge clk);
    checks++; if (bus.img_oob !== 1'b1) begin errors++; $display("FAIL oob_set_beats_clear: got %b, required 1", bus.img_oob); end
    bus.clr_err = 1'b1;
    tick();
    bus.clr_err = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_read_burst_overflow();
    int t0;
    t0 = cyc;
    for (int i = 0; i < 8; i++) begin
      bus.rd_req  = 1'b1;
      bus.rd_addr = ADDR_WIDTH'(100 + i);
      rd_q.push_back('{pat(ADDR_WIDTH'(100 + i)), cyc + 3});
      if (i < 6) drive_pixel(i, 5, 16'h1000 + i);
      else bus.img_pixel_ready = 1'b0;
      if (i < 4) push_wr(2400 + i, 16'h1000 + i, t0 + 9 + i);
      tick();
    end
    idle_inputs();
    repeat (8) tick();
    @(negedge clk);
    checks++; if (bus.img_overflow !== 1'b1) begin errors++; $display("FAIL overflow_set: got %b, required 1", bus.img_overflow); end
    checks++;
    if (wr_q.size() != 0 || rd_q.size() != 0) begin
      errors++;
      $display("FAIL burst_pending: got %0d writes %0d reads outstanding, required 0", wr_q.size(), rd_q.size());
    end
    tick();
    bus.clr_err = 1'b1;
    tick();
    bus.clr_err = 1'b0;
    @(negedge clk);
    checks++; if (bus.img_overflow !== 1'b0) begin errors++; $display("FAIL overflow_clear: got %b, required 0", bus.img_overflow); end
    tick();
  endtask

  task automatic test_capture();
    bus.cap_req  = 1'b1;
    bus.cap_addr = ADDR_WIDTH'(12345);
    bus.cap_data = 16'hCAFE;
    push_wr(12345, 16'hCAFE, cyc + 1);
    @(negedge clk);
    checks++; if (bus.cap_ack !== 1'b1) begin errors++; $display("FAIL capture_ack: got %b, required 1", bus.cap_ack); end
    tick();
    bus.cap_req = 1'b0;
    @(negedge clk);
    checks++; if (bus.cap_ack !== 1'b0) begin errors++; $display("FAIL capture_ack_drop: got %b, required 0", bus.cap_ack); end
    repeat (3) tick();
  endtask

  task automatic test_round_robin();
    logic exp_ack;
    for (int i = 0; i < 5; i++) begin
      bus.rd_req  = 1'b1;
      bus.rd_addr = ADDR_WIDTH'(300 + i);
      rd_q.push_back('{pat(ADDR_WIDTH'(300 + i)), cyc + 3});
      if (i < 4) drive_pixel(i, 10, 16'h2000 + i);
      else bus.img_pixel_ready = 1'b0;
      tick();
    end
    bus.rd_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus.cap_req  = 1'b1;
      bus.cap_addr = ADDR_WIDTH'(500 + k / 2);
      bus.cap_data = PIXEL_SIZE'(16'hC000 + k / 2);
      if (k % 2 == 0) push_wr(4800 + k / 2, 16'h2000 + k / 2, cyc + 1);
      else            push_wr(500 + k / 2, 16'hC000 + k / 2, cyc + 1);
      exp_ack = (k % 2 == 1);
      @(negedge clk);
      checks++;
      if (bus.cap_ack !== exp_ack) begin
        errors++;
        $display("FAIL rr_cap_ack_%0d: got %b, required %b", k, bus.cap_ack, exp_ack);
      end
      tick();
    end
    bus.cap_req = 1'b0;
    push_wr(4802, 16'h2002, cyc + 1);
    push_wr(4803, 16'h2003, cyc + 2);
    repeat (6) tick();
    checks++;
    if (wr_q.size() != 0 || rd_q.size() != 0) begin
      errors++;
      $display("FAIL rr_pending: got %0d writes %0d reads outstanding, required 0", wr_q.size(), rd_q.size());
    end
  endtask

  task automatic test_freeze();
    bus.ctrl_fg_freeze = 1'b1;
    bus.cap_req        = 1'b1;
    bus.cap_addr       = ADDR_WIDTH'(777);
    bus.cap_data       = 16'hBEEF;
    @(negedge clk);
    checks++; if (bus.cap_ack !== 1'b1) begin errors++; $display("FAIL freeze_ack: got %b, required 1", bus.cap_ack); end
    tick();
    bus.cap_req = 1'b0;
    @(negedge clk);
    checks++; if (bus.sram_en !== 1'b0) begin errors++; $display("FAIL freeze_sram_en: got %b, required 0", bus.sram_en); end
    tick();
    bus.ctrl_fg_freeze = 1'b0;
    @(negedge clk);
    checks++; if (bus.sram_en !== 1'b0) begin errors++; $display("FAIL freeze_sram_en_late: got %b, required 0", bus.sram_en); end
    repeat (2) tick();
  endtask

  // Three FIFO entries, one pixel in the address stage and reads in flight, then reset.
  task automatic test_reset_midop();
    for (int i = 0; i < 5; i++) begin
      bus.rd_req  = 1'b1;
      bus.rd_addr = ADDR_WIDTH'(400 + i);
      if (i < 2) rd_q.push_back('{pat(ADDR_WIDTH'(400 + i)), cyc + 3});
      if (i != 3) drive_pixel(i, 20, 16'h3000 + i);
      else bus.img_pixel_ready = 1'b0;
      tick();
    end
    test_reset("reset_midop");
  endtask

  initial begin
    idle_inputs();
    tick();
    test_reset("reset");
    fork
      scoreboard_monitor();
    join_none
    test_spi_write();
    test_oob();
    test_read_burst_overflow();
    test_capture();
    test_round_robin();
    test_freeze();
    test_reset_midop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
